uart_stream_ctrl: RTL and testbench
===================================

Name: uart_stream_ctrl

Overview:
- Sequencer that streams a block of bytes from a synchronous buffer RAM out through the uart transmitter.
- Applies host RTS/CTS flow control at byte boundaries.
- Sits between buf_ram (read port) and uart (transmit side).
- Replaces ad-hoc address counting and transmit gating in the top level with one clocked controller.

Parameters:
- ADDR_WIDTH, 9, buffer RAM address width; maximum block length is 2^ADDR_WIDTH bytes.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous cts_n input (minimum 2).

Ports:
- clk  input  1  master clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; begins a block transfer when idle.
- stop  input  1  level or pulse; ends the stream at the next byte boundary.
- loop_en  input  1  sampled at start; 1 = restart at address 0 after the last byte.
- length  input  ADDR_WIDTH+1  bytes per block, 1..2^ADDR_WIDTH; sampled at start.
- cts_n  input  1  asynchronous clear-to-send from the host RTS pin, active-low.
- ram_addr  output  ADDR_WIDTH  buffer RAM read address.
- ram_rdata  input  8  RAM read data, valid 1 cycle after ram_addr.
- uart_transmit  output  1  one-cycle transmit request to uart.
- uart_tx_byte  output  8  byte presented to uart; held stable from request until is_transmitting rises.
- uart_is_transmitting  input  1  uart busy flag.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on natural completion of a non-loop block.
- byte_count  output  ADDR_WIDTH+1  bytes handed to uart in the current block.

Behaviour:
- Reset: all outputs 0 (ram_addr, uart_tx_byte, byte_count all 0); state IDLE; synchronizer flops set to 1 (not clear). Reset mid-transfer aborts immediately. A byte already inside the uart is not recalled.
- cts_n passes through SYNC_STAGES flops. The controller uses only the synchronized value, cts_s. cts_s = 0 permits sending.

States:
- IDLE: on start with length != 0, latch length and loop_en, set ram_addr = 0 and byte_count = 0, go to FETCH. A start with length = 0 is ignored (stay IDLE, no done). start while busy is ignored.
- FETCH: wait one cycle for RAM latency, go to LATCH.
- LATCH: capture ram_rdata into uart_tx_byte, go to WAIT_CTS.
- WAIT_CTS:
  - stop high: go to IDLE, no done.
  - else cts_s = 0 and uart_is_transmitting = 0: go to SEND.
  - otherwise hold.
- SEND: uart_transmit = 1 for exactly this cycle, go to WAIT_ACK.
- WAIT_ACK: wait for uart_is_transmitting = 1, then byte_count++ and go to WAIT_DONE.
- WAIT_DONE: wait for uart_is_transmitting = 0, then evaluate the next step:
  - byte_count == length_latched and loop off: pulse done, go to IDLE.
  - byte_count == length_latched and loop on: ram_addr = 0, byte_count = 0, go to FETCH.
  - else ram_addr++ (wraps modulo 2^ADDR_WIDTH), go to FETCH.
  - stop high: go to IDLE, no done. stop takes priority over done and loop.

Timing and boundary rules:
- Minimum latency from start to first uart_transmit is 4 cycles (FETCH, LATCH, WAIT_CTS, SEND) plus synchronizer delay if cts was deasserted.
- CTS deasserting mid-byte never truncates a byte; it only blocks the next SEND.
- byte_count saturates logically at length; length = 2^ADDR_WIDTH sends every address exactly once.
- Simultaneous start and stop in IDLE: start wins; stop is sampled from the first WAIT_CTS onward.
- uart_transmit is never high in two consecutive cycles.

Test Plan:
- RAM[0..3] = 0x41,0x42,0x43,0x44, length = 4, cts_n = 0, start -> exactly four uart_transmit pulses carrying 0x41..0x44 in order; done pulses once; busy = 0; byte_count = 4.
- Same setup, cts_n = 1 raised after the first byte's transmit, held 2000 cycles, then lowered -> first byte completes; no transmit while cts_n is high; remaining three bytes follow after SYNC_STAGES + 1 cycles.
- length = 3, loop_en = 1, stop asserted during the 5th byte -> byte sequence RAM[0],[1],[2],[0],[1]; then IDLE; done never pulses.
- length = 512 (ADDR_WIDTH = 9) -> ram_addr runs 0..511; 512 transmits; ram_addr never wraps before done.
- start with length = 0 -> busy stays 0; no transmit; no done. start pulsed while busy -> ignored, byte stream unchanged.
- rst asserted in WAIT_ACK -> next cycle state is IDLE and all outputs 0; a new start afterwards begins again from address 0.

Source files
------------

// File: rtl/uart_stream_ctrl.sv
// -----------------------------------------------------------------------------
// uart_stream_ctrl
//
// Streams a block of bytes from a synchronous-read buffer RAM into the uart
// transmitter, one byte at a time. Host flow control (CTS, active-low) is
// honoured only at byte boundaries, so a byte that has been handed to the
// uart is never cut short.
//
// States
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | waiting for start; busy low
//   S_FETCH     | ram_addr presented, waiting out the one-cycle RAM latency
//   S_LATCH     | ram_rdata valid, captured into uart_tx_byte
//   S_WAIT_CTS  | byte ready; wait for host CTS and an idle uart (stop exits)
//   S_SEND      | uart_transmit high for this single cycle
//   S_WAIT_ACK  | wait for the uart to report it has taken the byte
//   S_WAIT_DONE | wait for the uart to finish, then pick the next address
//
// Ports
//   clk                   master clock
//   rst                   synchronous reset, active-high
//   start                 one-cycle pulse, starts a block when idle
//   stop                  ends the stream at the next byte boundary
//   loop_en               sampled at start; restart from address 0 after last byte
//   length                bytes per block (1..2^ADDR_WIDTH), sampled at start
//   cts_n                 asynchronous clear-to-send from host, active-low
//   ram_addr              buffer RAM read address
//   ram_rdata             RAM read data, valid one cycle after ram_addr
//   uart_transmit         one-cycle transmit request
//   uart_tx_byte          byte presented to the uart
//   uart_is_transmitting  uart busy flag
//   busy                  high whenever not idle
//   done                  one-cycle pulse when a non-loop block completes
//   byte_count            bytes handed to the uart in the current block
// -----------------------------------------------------------------------------
module uart_stream_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  cts_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_rdata,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count
);

  // A single flop is never an adequate synchronizer.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT_CTS,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] len_q;
  logic                loop_q;
  logic [SYNC_N-1:0]   cts_sync;
  logic                cts_s;

  // Synchronizer resets to 1 so the controller treats the host as
  // "not clear" until a real low level has propagated through.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_sync <= '1;
    end else begin
      cts_sync <= {cts_sync[SYNC_N-2:0], cts_n};
    end
  end

  assign cts_s = cts_sync[SYNC_N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      len_q         <= '0;
      loop_q        <= 1'b0;
      ram_addr      <= '0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      byte_count    <= '0;
    end else begin
      // Pulse outputs default low; they are raised only on the transition
      // that owns them.
      uart_transmit <= 1'b0;
      done          <= 1'b0;

      case (state)
        S_IDLE: begin
          // A zero-length start is dropped silently: no busy, no done.
          if (start && (length != '0)) begin
            len_q      <= length;
            loop_q     <= loop_en;
            ram_addr   <= '0;
            byte_count <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          uart_tx_byte <= ram_rdata;
          state        <= S_WAIT_CTS;
        end

        S_WAIT_CTS: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!cts_s && !uart_is_transmitting) begin
            uart_transmit <= 1'b1;
            state         <= S_SEND;
          end
        end

        S_SEND: begin
          state <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (uart_is_transmitting) begin
            byte_count <= byte_count + 1'b1;
            state      <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          // Byte boundary: stop beats both done and loop restart.
          if (!uart_is_transmitting) begin
            if (stop) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (byte_count == len_q) begin
              if (loop_q) begin
                ram_addr   <= '0;
                byte_count <= '0;
                state      <= S_FETCH;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              // Wraps naturally; only reachable past the top address when
              // length exceeds the RAM, which the block length range forbids.
              ram_addr <= ram_addr + 1'b1;
              state    <= S_FETCH;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_ctrl.sv
`timescale 1ns/1ps
module tb_uart_stream_ctrl;
  localparam int AW = 9;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW:0]   length = '0;
  logic          cts_n = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   byte_count;

  int checks = 0;
  int errors = 0;

  uart_stream_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .stop                 (stop),
    .loop_en              (loop_en),
    .length               (length),
    .cts_n                (cts_n),
    .ram_addr             (ram_addr),
    .ram_rdata            (ram_rdata),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .busy                 (busy),
    .done                 (done),
    .byte_count           (byte_count)
  );

  always #5 clk = ~clk;

  // Buffer RAM: synchronous read, one cycle latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  // UART model plus monitor, evaluated on the falling edge.
  int         pulses = 0;
  int         dones = 0;
  int         consec_err = 0;
  int         wrap_err = 0;
  int         ack_dly = 1;
  int         byte_cyc = 6;
  int         phase = 0;
  int         left = 0;
  logic       pending = 1'b0;
  logic       prev_tx = 1'b0;
  logic       prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0] rx_q [$];
  int         addr_q [$];

  always @(negedge clk) begin
    if (uart_transmit === 1'b1) begin
      pulses++;
      rx_q.push_back(uart_tx_byte);
      addr_q.push_back(int'(ram_addr));
      if (prev_tx) consec_err++;
      pending = 1'b1;
      phase   = ack_dly;
    end else if (pending) begin
      if (phase <= 1) begin
        pending = 1'b0;
        uart_is_transmitting = 1'b1;
        left = byte_cyc;
      end else begin
        phase--;
      end
    end else if (uart_is_transmitting) begin
      if (left <= 1) uart_is_transmitting = 1'b0;
      else left--;
    end
    if (done === 1'b1) dones++;
    if (busy === 1'b1 && prev_busy && ram_addr < prev_addr) wrap_err++;
    prev_tx   = (uart_transmit === 1'b1);
    prev_busy = (busy === 1'b1);
    prev_addr = ram_addr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    rx_q.delete();
    addr_q.delete();
    pulses = 0;
    dones  = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pulses >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b expected 0", uart_transmit); end
    checks++; if (ram_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", uart_tx_byte); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int lat;
    bit ok;
    logic [7:0] exp_b;
    clear_log();
    length  = 10'd4;
    loop_en = 1'b0;
    pulse_start();
    lat = 1;
    while (uart_transmit !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 4", lat); end
    wait_idle(500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: busy still %b expected 0", busy); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL basic_pulses: got %0d expected 4", pulses); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      exp_b = 8'h41 + 8'(i);
      checks++; if (rx_q[i] !== exp_b) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp_b); end
    end
    tick();
    checks++; if (dones !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", dones); end
    checks++; if (byte_count !== 10'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", byte_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_low: got %b expected 0", done); end
  endtask

  task automatic test_cts();
    bit ok;
    int bad;
    int n;
    logic [7:0] exp_b;
    clear_log();
    length  = 10'd4;
    loop_en = 1'b0;
    pulse_start();
    wait_pulses(1, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cts_first_timeout: got %0d pulses expected 1", pulses); end
    cts_n = 1'b1;
    bad = 0;
    repeat (2000) begin
      tick();
      if (pulses != 1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL cts_blocked: got %0d bad cycles expected 0", bad); end
    checks++; if (byte_count !== 10'd1) begin errors++; $display("FAIL cts_first_done: got %0d expected 1", byte_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cts_busy_hold: got %b expected 1", busy); end
    cts_n = 1'b0;
    n = 0;
    while (pulses == 1 && n < 50) begin
      tick();
      n++;
    end
    checks++; if (n !== SS + 1) begin errors++; $display("FAIL cts_resume: got %0d cycles expected %0d", n, SS + 1); end
    wait_idle(500, ok);
    checks++; if (pulses !== 4) begin errors++; $display("FAIL cts_pulses: got %0d expected 4", pulses); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      exp_b = 8'h41 + 8'(i);
      checks++; if (rx_q[i] !== exp_b) begin errors++; $display("FAIL cts_byte%0d: got %h expected %h", i, rx_q[i], exp_b); end
    end
    tick();
    checks++; if (dones !== 1) begin errors++; $display("FAIL cts_done: got %0d expected 1", dones); end
  endtask

  task automatic test_loop_stop();
    bit ok;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42};
    clear_log();
    length  = 10'd3;
    loop_en = 1'b1;
    pulse_start();
    loop_en = 1'b0;
    wait_pulses(5, 500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_timeout: got %0d pulses expected 5", pulses); end
    stop = 1'b1;
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_stop_idle: busy %b expected 0", busy); end
    stop = 1'b0;
    repeat (20) tick();
    checks++; if (pulses !== 5) begin errors++; $display("FAIL loop_pulses: got %0d expected 5", pulses); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_seq[i]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", i, rx_q[i], exp_seq[i]); end
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL loop_done: got %0d expected 0", dones); end
    checks++; if (byte_count !== 10'd2) begin errors++; $display("FAIL loop_count: got %0d expected 2", byte_count); end
  endtask

  task automatic test_zero_len();
    int bad;
    clear_log();
    length = 10'd0;
    pulse_start();
    bad = 0;
    repeat (30) begin
      if (busy !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", bad); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", pulses); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL zero_done: got %0d expected 0", dones); end
  endtask

  task automatic test_busy_start();
    bit ok;
    logic [7:0] exp_b;
    clear_log();
    length  = 10'd4;
    loop_en = 1'b0;
    pulse_start();
    wait_pulses(1, 100, ok);
    length  = 10'd2;
    loop_en = 1'b1;
    pulse_start();
    loop_en = 1'b0;
    wait_idle(1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_start_timeout: busy %b expected 0", busy); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 4", pulses); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      exp_b = 8'h41 + 8'(i);
      checks++; if (rx_q[i] !== exp_b) begin errors++; $display("FAIL busy_start_byte%0d: got %h expected %h", i, rx_q[i], exp_b); end
    end
    tick();
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    ack_dly = 4;
    length  = 10'd4;
    loop_en = 1'b0;
    pulse_start();
    wait_pulses(2, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_timeout: got %0d pulses expected 2", pulses); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ram_addr !== 9'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", ram_addr); end
    checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", byte_count); end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h expected 00", uart_tx_byte); end
    checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL rstmid_transmit: got %b expected 0", uart_transmit); end
    rst = 1'b0;
    ack_dly = 1;
    repeat (3) tick();
    clear_log();
    pulse_start();
    wait_idle(1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_restart_timeout: busy %b expected 0", busy); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 4", pulses); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== 8'h41) begin errors++; $display("FAIL rstmid_first_byte: got %h expected 41", rx_q[0]); end
      checks++; if (addr_q[0] !== 0) begin errors++; $display("FAIL rstmid_first_addr: got %0d expected 0", addr_q[0]); end
    end
    tick();
    checks++; if (dones !== 1) begin errors++; $display("FAIL rstmid_done: got %0d expected 1", dones); end
  endtask

  task automatic test_full_length();
    bit ok;
    int bad_data;
    int bad_addr;
    logic [7:0] exp_b;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h5A;
    byte_cyc = 3;
    clear_log();
    wrap_err = 0;
    length   = 10'd512;
    loop_en  = 1'b0;
    pulse_start();
    wait_idle(20000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout: got %0d pulses", pulses); end
    checks++; if (pulses !== 512) begin errors++; $display("FAIL full_pulses: got %0d expected 512", pulses); end
    bad_data = 0;
    bad_addr = 0;
    for (int i = 0; i < 512 && i < rx_q.size(); i++) begin
      exp_b = 8'(i) ^ 8'h5A;
      if (rx_q[i] !== exp_b) bad_data++;
      if (addr_q[i] !== i) bad_addr++;
    end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL full_data: got %0d bad bytes expected 0", bad_data); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL full_addr: got %0d bad addresses expected 0", bad_addr); end
    checks++; if (wrap_err !== 0) begin errors++; $display("FAIL full_wrap: got %0d wraps expected 0", wrap_err); end
    checks++; if (ram_addr !== 9'd511) begin errors++; $display("FAIL full_last_addr: got %0d expected 511", ram_addr); end
    checks++; if (byte_count !== 10'd512) begin errors++; $display("FAIL full_count: got %0d expected 512", byte_count); end
    tick();
    checks++; if (dones !== 1) begin errors++; $display("FAIL full_done: got %0d expected 1", dones); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[0] = 8'h41;
    mem[1] = 8'h42;
    mem[2] = 8'h43;
    mem[3] = 8'h44;
    test_reset();
    test_basic();
    test_cts();
    test_loop_stop();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    test_full_length();
    checks++; if (consec_err !== 0) begin errors++; $display("FAIL transmit_consecutive: got %0d expected 0", consec_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
